// File: rtl/rob_commit_if.sv
// Issue / CDB / commit bundle between the reorder buffer and the rest of the core.
// The ROB takes the slave side; the issue stage, CDB and register file form the master side.
interface rob_commit_if #(
    parameter int ROB_IDX = 4,
    parameter int XLEN    = 32
);
    // Allocation from the instruction queue
    logic               alloc_valid;
    logic [4:0]         alloc_rd;
    logic               alloc_is_branch;
    logic [ROB_IDX-1:0] alloc_tag;
    logic               rob_full;

    // Common data bus
    logic               cdb_valid;
    logic [ROB_IDX-1:0] cdb_tag;
    logic [XLEN-1:0]    cdb_value;
    logic               cdb_mispredict;
    logic [XLEN-1:0]    cdb_target;

    // Register-file commit port
    logic [4:0]         commit_rd;
    logic               reg_busy_commit_rd;
    logic [ROB_IDX-1:0] reg_reorder_commit_rd;
    logic               ROB_to_Reg_needchange;
    logic [XLEN-1:0]    reg_reg_commit_rd_;
    logic               reg_busy_commit_rd_;

    // Flush
    logic               Clear_flag;
    logic [XLEN-1:0]    clear_pc;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_is_branch,
        output alloc_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
        output commit_rd,
        input  reg_busy_commit_rd, reg_reorder_commit_rd,
        output ROB_to_Reg_needchange, reg_reg_commit_rd_, reg_busy_commit_rd_,
        output Clear_flag, clear_pc
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_is_branch,
        input  alloc_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
        input  commit_rd,
        output reg_busy_commit_rd, reg_reorder_commit_rd,
        input  ROB_to_Reg_needchange, reg_reg_commit_rd_, reg_busy_commit_rd_,
        input  Clear_flag, clear_pc
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: circular queue that allocates in issue order, captures CDB
// results out of order, retires one head entry per cycle into the register
// file and raises a one-cycle flush when a mispredicted branch retires.
module rob_commit #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_IDX  = 4,
    parameter int XLEN     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rdy,
    rob_commit_if.slave     bus
);
    localparam logic [ROB_IDX:0]   CNT_FULL = (ROB_IDX+1)'(ROB_SIZE);
    localparam logic [ROB_IDX:0]   CNT_ONE  = (ROB_IDX+1)'(1);
    localparam logic [ROB_IDX-1:0] PTR_ONE  = ROB_IDX'(1);

    // Control state (reset)
    logic [ROB_IDX-1:0]  r_head;
    logic [ROB_IDX-1:0]  r_tail;
    logic [ROB_IDX:0]    r_count;
    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_ready;
    logic                r_clear_flag;
    logic [XLEN-1:0]     r_clear_pc;

    // Entry payload (not reset)
    logic [4:0]          r_rd         [ROB_SIZE];
    logic                r_is_branch  [ROB_SIZE];
    logic [XLEN-1:0]     r_value      [ROB_SIZE];
    logic                r_mispredict [ROB_SIZE];
    logic [XLEN-1:0]     r_target     [ROB_SIZE];

    logic w_full;
    logic w_alloc_fire;
    logic w_cdb_fire;
    logic w_commit_fire;
    logic w_flush;
    logic w_younger_rename;

    // Handshake qualifiers; the global stall is applied where state is updated.
    always_comb begin
        w_full           = (r_count == CNT_FULL);
        w_alloc_fire     = bus.alloc_valid && !w_full && !r_clear_flag;
        w_cdb_fire       = bus.cdb_valid && r_valid[bus.cdb_tag] && !r_clear_flag;
        w_commit_fire    = r_valid[r_head] && r_ready[r_head] && !r_clear_flag;
        w_flush          = w_commit_fire && r_is_branch[r_head] && r_mispredict[r_head];
        w_younger_rename = w_alloc_fire && (bus.alloc_rd != 5'd0) &&
                           (bus.alloc_rd == r_rd[r_head]);
    end

    // Commit-port and status outputs; zero whenever nothing retires.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        bus.alloc_tag             = r_tail;
        bus.rob_full              = w_full;
        bus.Clear_flag            = r_clear_flag;
        bus.clear_pc              = r_clear_pc;
        bus.commit_rd             = 5'd0;
        bus.ROB_to_Reg_needchange = 1'b0;
        bus.reg_reg_commit_rd_    = '0;
        bus.reg_busy_commit_rd_   = 1'b0;
        if (w_commit_fire) begin
            bus.commit_rd             = r_rd[r_head];
            bus.ROB_to_Reg_needchange = (r_rd[r_head] != 5'd0);
            bus.reg_reg_commit_rd_    = r_value[r_head];
            // A younger in-flight rename of this register must keep it busy.
            bus.reg_busy_commit_rd_   = (bus.reg_reorder_commit_rd != r_head) ||
                                        w_younger_rename;
        end
    end

    // Pointers, occupancy, per-entry valid/ready and the flush pulse.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_valid      <= '0;
            r_ready      <= '0;
            r_clear_flag <= 1'b0;
            r_clear_pc   <= '0;
        end else if (i_rdy) begin
            if (r_clear_flag) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_valid      <= '0;
                r_ready      <= '0;
                r_clear_flag <= 1'b0;
            end else begin
                if (w_alloc_fire) begin
                    r_valid[r_tail] <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + PTR_ONE;
                end
                if (w_cdb_fire) begin
                    r_ready[bus.cdb_tag] <= 1'b1;
                end
                if (w_commit_fire) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + PTR_ONE;
                end
                if (w_flush) begin
                    r_clear_flag <= 1'b1;
                    r_clear_pc   <= r_target[r_head];
                end
                case ({w_alloc_fire, w_commit_fire})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry payload capture at allocation and at CDB writeback.
    // NOTE: payload storage is deliberately not reset; it is only read once its valid/ready bit is set.
    always_ff @(posedge i_clk) begin
        if (i_rdy) begin
            if (w_alloc_fire) begin
                r_rd[r_tail]         <= bus.alloc_rd;
                r_is_branch[r_tail]  <= bus.alloc_is_branch;
                r_mispredict[r_tail] <= 1'b0;
            end
            if (w_cdb_fire) begin
                r_value[bus.cdb_tag]      <= bus.cdb_value;
                r_mispredict[bus.cdb_tag] <= bus.cdb_mispredict;
                r_target[bus.cdb_tag]     <= bus.cdb_target;
            end
        end
    end
endmodule
